// File: rtl/vx_stream_skid_buffer.sv
// Two-entry valid/ready skid buffer: registers both the forward (valid/data)
// and backward (ready) paths so no combinational path crosses the block.
module vx_stream_skid_buffer #(
  parameter int DATAW    = 1,
  parameter bit PASSTHRU = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic [1:0]       size
);

  if (PASSTHRU) begin : g_passthru
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
    assign size      = 2'd0;
  end else begin : g_buffer
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_r;
    logic [DATAW-1:0] main_r;
    logic [DATAW-1:0] skid_r;
    logic             fire_in;
    logic             fire_out;

    // All outputs decode from registered state only; nothing flows through.
    assign valid_out = (state_r != ST_EMPTY);
    assign ready_in  = (state_r != ST_FULL);
    assign data_out  = main_r;
    assign size      = state_r;  // state encoding doubles as occupancy

    assign fire_in  = valid_in & ready_in;
    assign fire_out = valid_out & ready_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= ST_EMPTY;
        main_r  <= '0;
        skid_r  <= '0;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (fire_in) begin
              state_r <= ST_ONE;
              main_r  <= data_in;
            end
          end
          ST_ONE: begin
            if (fire_in && !fire_out) begin
              state_r <= ST_FULL;
              skid_r  <= data_in;
            end else if (fire_in && fire_out) begin
              main_r  <= data_in;
            end else if (fire_out) begin
              state_r <= ST_EMPTY;
            end
          end
          ST_FULL: begin
            if (fire_out) begin
              state_r <= ST_ONE;
              main_r  <= skid_r;
            end
          end
          default: state_r <= ST_EMPTY;
        endcase
      end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
      if (!reset) begin
        assert (state_r != 2'b11);
        assert (size != 2'd3);
        assert (!(fire_in && (state_r == ST_FULL)));
      end
    end
`endif
  end

endmodule
